// File: rtl/addsub_issue_ctrl.sv
// addsub_issue_ctrl: issues operand pairs to an external 8-bit adder/subtractor,
// holds them stable for SETTLE_CYCLES, captures the result with a sign flag and
// buffers it in a small FIFO for a valid/ready consumer.
module addsub_issue_ctrl #(
    parameter int SETTLE_CYCLES = 1,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    input  logic        in_mode,
    output logic [7:0]  add_a,
    output logic [7:0]  add_b,
    output logic        add_mode,
    input  logic [7:0]  add_sum,
    input  logic [7:0]  add_gray,
    input  logic        add_carry,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_sum,
    output logic [7:0]  out_gray,
    output logic        out_carry,
    output logic        out_neg,
    output logic [15:0] op_count
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 18;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]       SETTLE_C = 4'(SETTLE_CYCLES);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SETTLE = 1'b1;

    logic [0:0]         r_state;
    logic [3:0]         r_settle_cnt;
    logic [7:0]         r_add_a;
    logic [7:0]         r_add_b;
    logic               r_add_mode;
    logic [15:0]        r_op_count;

    logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_accept;
    logic               w_capture;
    logic               w_pop;
    logic               w_neg;
    logic [ENTRY_W-1:0] w_entry;
    logic [ENTRY_W-1:0] w_head;

    // Space is checked against the count at acceptance; since only a pop can
    // change the count while an op is in flight, the later push always fits.
    assign in_ready  = (r_state == ST_IDLE) && (r_count < DEPTH_C);
    assign w_accept  = in_valid && in_ready;
    assign w_capture = (r_state == ST_SETTLE) && (r_settle_cnt == 4'd1);
    assign w_neg     = r_add_mode & ~add_carry;
    assign w_entry   = {add_sum, add_gray, add_carry, w_neg};
    assign w_pop     = out_valid && out_ready;

    assign add_a    = r_add_a;
    assign add_b    = r_add_b;
    assign add_mode = r_add_mode;
    assign op_count = r_op_count;

    // Outputs come only from FIFO storage; an empty FIFO reads as zero.
    assign out_valid = (r_count != '0);
    assign w_head    = r_mem[r_rd_ptr];
    assign out_sum   = out_valid ? w_head[17:10] : 8'd0;
    assign out_gray  = out_valid ? w_head[9:2]   : 8'd0;
    assign out_carry = out_valid ? w_head[1]     : 1'b0;
    assign out_neg   = out_valid ? w_head[0]     : 1'b0;

    // Issue FSM: accept in IDLE, count down the settle time, capture on the last cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state      <= ST_SETTLE;
                        r_settle_cnt <= SETTLE_C;
                    end
                end
                ST_SETTLE: begin
                    r_settle_cnt <= r_settle_cnt - 4'd1;
                    if (w_capture) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_settle_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Operand registers drive the adder and hold until the next acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_add_a    <= 8'd0;
            r_add_b    <= 8'd0;
            r_add_mode <= 1'b0;
        end else if (w_accept) begin
            r_add_a    <= in_a;
            r_add_b    <= in_b;
            r_add_mode <= in_mode;
        end
    end

    // Completed-result counter, free-running modulo 2^16.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_count <= 16'd0;
        end else if (w_capture) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    // Result storage; contents are only observed through a nonzero count.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_capture) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_capture, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_issue_ctrl.sv
// Directed testbench for addsub_issue_ctrl: one instance with the default
// settle time and one with SETTLE_CYCLES=3, each wired to a behavioural adder.
module tb_addsub_issue_ctrl;

    logic        clk;
    logic        rst;
    int          checks;
    int          errors;

    // Instance with SETTLE_CYCLES=1, FIFO_DEPTH=4
    logic        in_valid, in_ready, in_mode;
    logic [7:0]  in_a, in_b;
    logic [7:0]  add_a, add_b, add_sum, add_gray;
    logic        add_mode, add_carry;
    logic        out_valid, out_ready, out_carry, out_neg;
    logic [7:0]  out_sum, out_gray;
    logic [15:0] op_count;

    // Instance with SETTLE_CYCLES=3
    logic        d3_in_valid, d3_in_ready, d3_in_mode;
    logic [7:0]  d3_in_a, d3_in_b;
    logic [7:0]  d3_add_a, d3_add_b, d3_add_sum, d3_add_gray;
    logic        d3_add_mode, d3_add_carry;
    logic        d3_out_valid, d3_out_ready, d3_out_carry, d3_out_neg;
    logic [7:0]  d3_out_sum, d3_out_gray;
    logic [15:0] d3_op_count;

    addsub_issue_ctrl #(.SETTLE_CYCLES(1), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
        .add_a(add_a), .add_b(add_b), .add_mode(add_mode),
        .add_sum(add_sum), .add_gray(add_gray), .add_carry(add_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_gray(out_gray),
        .out_carry(out_carry), .out_neg(out_neg),
        .op_count(op_count)
    );

    addsub_issue_ctrl #(.SETTLE_CYCLES(3), .FIFO_DEPTH(4)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_valid(d3_in_valid), .in_ready(d3_in_ready),
        .in_a(d3_in_a), .in_b(d3_in_b), .in_mode(d3_in_mode),
        .add_a(d3_add_a), .add_b(d3_add_b), .add_mode(d3_add_mode),
        .add_sum(d3_add_sum), .add_gray(d3_add_gray), .add_carry(d3_add_carry),
        .out_valid(d3_out_valid), .out_ready(d3_out_ready),
        .out_sum(d3_out_sum), .out_gray(d3_out_gray),
        .out_carry(d3_out_carry), .out_neg(d3_out_neg),
        .op_count(d3_op_count)
    );

    // Behavioural adder/subtractor: subtract returns magnitude, carry=1 when A>=B
    always_comb begin
        add_sum   = 8'd0;
        add_carry = 1'b0;
        if (!add_mode) begin
            {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b};
        end else if (add_a >= add_b) begin
            add_sum   = add_a - add_b;
            add_carry = 1'b1;
        end else begin
            add_sum   = add_b - add_a;
            add_carry = 1'b0;
        end
        add_gray = add_sum ^ (add_sum >> 1);
    end

    always_comb begin
        d3_add_sum   = 8'd0;
        d3_add_carry = 1'b0;
        if (!d3_add_mode) begin
            {d3_add_carry, d3_add_sum} = {1'b0, d3_add_a} + {1'b0, d3_add_b};
        end else if (d3_add_a >= d3_add_b) begin
            d3_add_sum   = d3_add_a - d3_add_b;
            d3_add_carry = 1'b1;
        end else begin
            d3_add_sum   = d3_add_b - d3_add_a;
            d3_add_carry = 1'b0;
        end
        d3_add_gray = d3_add_sum ^ (d3_add_sum >> 1);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an op on the default instance and wait (bounded) for acceptance
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic m);
        bit ok;
        ok = 1'b0;
        in_a = a; in_b = b; in_mode = m; in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: accepted=%0d required=1 (a=%0d b=%0d)", ok, a, b);
        end
    endtask

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0d want 0", out_valid); end
        checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL rst_op_count: got %0d want 0", op_count); end
        checks++; if (add_a !== 8'd0 || add_b !== 8'd0 || add_mode !== 1'b0) begin errors++; $display("FAIL rst_add_regs: got a=%0d b=%0d m=%0d want 0", add_a, add_b, add_mode); end
        checks++; if (out_sum !== 8'd0 || out_gray !== 8'd0 || out_carry !== 1'b0 || out_neg !== 1'b0) begin errors++; $display("FAIL rst_out_data: got sum=%0d gray=%0d c=%0d n=%0d want 0", out_sum, out_gray, out_carry, out_neg); end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0d want 1", in_ready); end
        // First op: 200 + 100 with SETTLE=1
        in_a = 8'd200; in_b = 8'd100; in_mode = 1'b0; in_valid = 1'b1;
        step();                       // T0: accepted
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL add_settle: got valid=%0d ready=%0d want 0,0", out_valid, in_ready); end
        checks++; if (add_a !== 8'd200 || add_b !== 8'd100) begin errors++; $display("FAIL add_regs: got a=%0d b=%0d want 200,100", add_a, add_b); end
        step();                       // T1: captured
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %0d want 1", out_valid); end
        checks++; if (out_sum !== 8'd44 || out_gray !== 8'd58 || out_carry !== 1'b1 || out_neg !== 1'b0) begin errors++; $display("FAIL add_result: got sum=%0d gray=%0d c=%0d n=%0d want 44,58,1,0", out_sum, out_gray, out_carry, out_neg); end
        checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL add_op_count: got %0d want 1", op_count); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_pop: got valid=%0d want 0", out_valid); end
    endtask

    task automatic test_neg_sub();
        do_op(8'd50, 8'd80, 1'b1);
        step();
        checks++; if (out_valid !== 1'b1 || out_sum !== 8'd30 || out_gray !== 8'd17 || out_carry !== 1'b0 || out_neg !== 1'b1) begin errors++; $display("FAIL neg_sub: got v=%0d sum=%0d gray=%0d c=%0d n=%0d want 1,30,17,0,1", out_valid, out_sum, out_gray, out_carry, out_neg); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_sum !== 8'd0) begin errors++; $display("FAIL neg_pop: got v=%0d sum=%0d want 0,0", out_valid, out_sum); end
    endtask

    task automatic test_back_to_back();
        in_a = 8'd80; in_b = 8'd50; in_mode = 1'b1; in_valid = 1'b1;
        step();                       // accept 80-50
        in_a = 8'd5; in_b = 8'd5;     // ignored while busy
        checks++; if (in_ready !== 1'b0 || add_a !== 8'd80) begin errors++; $display("FAIL b2b_busy: got ready=%0d add_a=%0d want 0,80", in_ready, add_a); end
        step();                       // capture first
        checks++; if (in_ready !== 1'b1 || add_a !== 8'd80) begin errors++; $display("FAIL b2b_capture: got ready=%0d add_a=%0d want 1,80", in_ready, add_a); end
        step();                       // accept 5-5, two cycles after first acceptance
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || add_a !== 8'd5) begin errors++; $display("FAIL b2b_gap: got ready=%0d add_a=%0d want 0,5", in_ready, add_a); end
        step();                       // capture second
        checks++; if (op_count !== 16'd4) begin errors++; $display("FAIL b2b_op_count: got %0d want 4", op_count); end
        checks++; if (out_sum !== 8'd30 || out_gray !== 8'd17 || out_carry !== 1'b1 || out_neg !== 1'b0) begin errors++; $display("FAIL b2b_first: got sum=%0d gray=%0d c=%0d n=%0d want 30,17,1,0", out_sum, out_gray, out_carry, out_neg); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_sum !== 8'd0 || out_gray !== 8'd0 || out_carry !== 1'b1 || out_neg !== 1'b0) begin errors++; $display("FAIL b2b_second: got v=%0d sum=%0d gray=%0d c=%0d n=%0d want 1,0,0,1,0", out_valid, out_sum, out_gray, out_carry, out_neg); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %0d want 0", out_valid); end
    endtask

    task automatic test_full_fifo();
        logic [7:0] exp_sum  [4];
        logic [7:0] exp_gray [4];
        exp_sum  = '{8'd22, 8'd33, 8'd127, 8'd16};
        exp_gray = '{8'd29, 8'd49, 8'd64,  8'd24};
        out_ready = 1'b0;
        do_op(8'd10, 8'd1, 1'b0);
        do_op(8'd20, 8'd2, 1'b0);
        do_op(8'd30, 8'd3, 1'b0);
        do_op(8'd100, 8'd27, 1'b0);
        step();                       // fourth capture, FIFO full
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0d want 0", in_ready); end
        checks++; if (out_sum !== 8'd11 || op_count !== 16'd8) begin errors++; $display("FAIL full_head: got sum=%0d cnt=%0d want 11,8", out_sum, op_count); end
        in_a = 8'd7; in_b = 8'd9; in_mode = 1'b0; in_valid = 1'b1;
        repeat (3) step();
        checks++; if (in_ready !== 1'b0 || add_a !== 8'd100) begin errors++; $display("FAIL full_hold: got ready=%0d add_a=%0d want 0,100", in_ready, add_a); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_sum !== 8'd22) begin errors++; $display("FAIL full_one_pop: got ready=%0d sum=%0d want 1,22", in_ready, out_sum); end
        step();                       // fifth op accepted
        in_valid = 1'b0;
        checks++; if (add_a !== 8'd7 || add_b !== 8'd9) begin errors++; $display("FAIL full_fifth: got a=%0d b=%0d want 7,9", add_a, add_b); end
        step();                       // fifth captured
        checks++; if (in_ready !== 1'b0 || op_count !== 16'd9) begin errors++; $display("FAIL full_again: got ready=%0d cnt=%0d want 0,9", in_ready, op_count); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_sum !== exp_sum[k] || out_gray !== exp_gray[k] || out_carry !== 1'b0 || out_neg !== 1'b0) begin
                errors++;
                $display("FAIL full_order[%0d]: got v=%0d sum=%0d gray=%0d c=%0d n=%0d want 1,%0d,%0d,0,0", k, out_valid, out_sum, out_gray, out_carry, out_neg, exp_sum[k], exp_gray[k]);
            end
            out_ready = 1'b1; step(); out_ready = 1'b0;
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_empty: got %0d want 0", out_valid); end
    endtask

    task automatic test_push_pop();
        out_ready = 1'b1;
        in_a = 8'd1; in_b = 8'd1; in_mode = 1'b0; in_valid = 1'b1;
        step();                       // accept 1+1
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pp_idle0: got %0d want 0", out_valid); end
        in_a = 8'd3; in_b = 8'd3;
        step();                       // capture 2
        checks++; if (out_valid !== 1'b1 || out_sum !== 8'd2) begin errors++; $display("FAIL pp_first: got v=%0d sum=%0d want 1,2", out_valid, out_sum); end
        step();                       // pop 2, accept 3+3
        checks++; if (out_valid !== 1'b0 || add_a !== 8'd3) begin errors++; $display("FAIL pp_pop_accept: got v=%0d add_a=%0d want 0,3", out_valid, add_a); end
        in_valid = 1'b0;
        step();                       // capture 6
        checks++; if (out_valid !== 1'b1 || out_sum !== 8'd6 || out_gray !== 8'd5) begin errors++; $display("FAIL pp_second: got v=%0d sum=%0d gray=%0d want 1,6,5", out_valid, out_sum, out_gray); end
        step();
        checks++; if (out_valid !== 1'b0 || op_count !== 16'd11) begin errors++; $display("FAIL pp_end: got v=%0d cnt=%0d want 0,11", out_valid, op_count); end
        out_ready = 1'b0;
    endtask

    task automatic test_settle3();
        d3_in_a = 8'd9; d3_in_b = 8'd4; d3_in_mode = 1'b1; d3_in_valid = 1'b1;
        step();                       // T0
        d3_in_valid = 1'b0;
        checks++; if (d3_add_a !== 8'd9 || d3_in_ready !== 1'b0) begin errors++; $display("FAIL s3_accept: got a=%0d ready=%0d want 9,0", d3_add_a, d3_in_ready); end
        step(); step();               // T0+2
        checks++; if (d3_out_valid !== 1'b0) begin errors++; $display("FAIL s3_early: got %0d want 0", d3_out_valid); end
        step();                       // T0+3 capture
        checks++; if (d3_out_valid !== 1'b1 || d3_out_sum !== 8'd5 || d3_out_carry !== 1'b1 || d3_out_neg !== 1'b0 || d3_op_count !== 16'd1) begin errors++; $display("FAIL s3_result: got v=%0d sum=%0d c=%0d n=%0d cnt=%0d want 1,5,1,0,1", d3_out_valid, d3_out_sum, d3_out_carry, d3_out_neg, d3_op_count); end
        d3_out_ready = 1'b1; step(); d3_out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        d3_in_a = 8'd200; d3_in_b = 8'd1; d3_in_mode = 1'b1; d3_in_valid = 1'b1;
        step();                       // T0 accept
        d3_in_valid = 1'b0;
        step();                       // T0+1, still settling
        rst = 1'b1;
        #1;
        checks++; if (d3_add_a !== 8'd0 || d3_add_b !== 8'd0 || d3_add_mode !== 1'b0) begin errors++; $display("FAIL mid_rst_add: got a=%0d b=%0d m=%0d want 0", d3_add_a, d3_add_b, d3_add_mode); end
        checks++; if (d3_op_count !== 16'd0 || op_count !== 16'd0) begin errors++; $display("FAIL mid_rst_count: got d3=%0d d1=%0d want 0,0", d3_op_count, op_count); end
        checks++; if (d3_out_valid !== 1'b0 || d3_out_sum !== 8'd0) begin errors++; $display("FAIL mid_rst_out: got v=%0d sum=%0d want 0,0", d3_out_valid, d3_out_sum); end
        step(); step();
        rst = 1'b0;
        repeat (4) step();
        checks++; if (d3_out_valid !== 1'b0 || d3_op_count !== 16'd0) begin errors++; $display("FAIL mid_no_push: got v=%0d cnt=%0d want 0,0", d3_out_valid, d3_op_count); end
        checks++; if (d3_in_ready !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got d3=%0d d1=%0d want 1,1", d3_in_ready, in_ready); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1;
        in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0; in_mode = 1'b0; out_ready = 1'b0;
        d3_in_valid = 1'b0; d3_in_a = 8'd0; d3_in_b = 8'd0; d3_in_mode = 1'b0; d3_out_ready = 1'b0;
        #12;
        test_reset();
        test_neg_sub();
        test_back_to_back();
        test_full_fifo();
        test_push_pop();
        test_settle3();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_issue_ctrl.md
Name: addsub_issue_ctrl

Overview:
- Sequencing stage that wraps the 8-bit combinational adder/subtractor: upstream and downstream of it at once.
- Accepts operand/mode pairs over a valid/ready handshake and holds them stable on the adder inputs for a programmable settle time.
- Captures the adder's SUM/gray/carry, derives a sign flag, and buffers results in a small FIFO for a valid/ready consumer.

Parameters:
- SETTLE_CYCLES, 1, cycles the operands are held on the adder before capture; legal range 1..15.
- FIFO_DEPTH, 4, number of result entries buffered; must be a power of two, 2..16.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand pair present
- in_ready  output  1  block accepts operand pair this cycle
- in_a  input  8  operand A
- in_b  input  8  operand B
- in_mode  input  1  0 = add, 1 = subtract (A-B)
- add_a  output  8  registered operand A to adder
- add_b  output  8  registered operand B to adder
- add_mode  output  1  registered mode to adder
- add_sum  input  8  adder SUM (magnitude when subtract result is negative)
- add_gray  input  8  adder gray-code of SUM
- add_carry  input  1  adder carry
- out_valid  output  1  FIFO head result valid
- out_ready  input  1  consumer takes head result
- out_sum  output  8  result magnitude
- out_gray  output  8  gray code of out_sum
- out_carry  output  1  captured carry
- out_neg  output  1  1 when subtract result is negative
- op_count  output  16  results written into the FIFO since reset

Behaviour:
- Reset (asynchronous, active-high) forces all of the following, regardless of clk:
  - state = IDLE, settle counter = 0, FIFO empty (pointers and count = 0).
  - add_a = 0, add_b = 0, add_mode = 0, op_count = 0.
  - out_valid = 0; out_sum, out_gray, out_carry and out_neg read 0.
  - An in-flight operation is discarded; no partial result is ever pushed.
- State machine has two states, IDLE and SETTLE:
  - IDLE: in_ready = 1 iff fifo_count < FIFO_DEPTH. On in_valid & in_ready at edge T0, register add_a/add_b/add_mode, load counter = SETTLE_CYCLES, and go to SETTLE.
  - SETTLE: in_ready = 0. The counter decrements every edge. On the edge where the counter equals 1 (edge T0+SETTLE_CYCLES), push the entry {add_sum, add_gray, add_carry, neg}, increment op_count, and return to IDLE.
- neg = add_mode & ~add_carry.
- add_* outputs hold their values after capture until the next acceptance.
- Throughput: at most one operation per SETTLE_CYCLES+1 cycles. No acceptance occurs on the capture edge.
- Latency: out_valid rises immediately after the capture edge when the FIFO was empty. Minimum latency is SETTLE_CYCLES edges from acceptance.
- Output side:
  - out_* always show the FIFO head, with no combinational path from add_* to out_*.
  - A pop occurs on out_valid & out_ready.
  - out_valid = (fifo_count != 0).
- Full and empty handling:
  - Acceptance requires free space, and count can only drop while an operation is in flight, so a push never overflows.
  - A pop when empty is ignored.
  - When push and pop fall on the same edge, count is unchanged and the head advances.
  - Pointers wrap modulo FIFO_DEPTH.
- op_count wraps from 16'hFFFF to 0.
- in_a/in_b/in_mode are ignored whenever in_ready = 0. Holding in_valid high across a busy period is legal.

Test Plan:
- Reset behaviour: reset, then in_a=200, in_b=100, mode=0 with SETTLE=1. The op is accepted at T0 and out_valid rises after T1. Required output: out_sum=44, out_gray=58, out_carry=1, out_neg=0, op_count=1.
- Negative subtract: in_a=50, in_b=80, mode=1 -> out_sum=30, out_gray=17, out_carry=0, out_neg=1.
- Positive and zero subtract, back to back:
  - 80-50 -> sum=30, carry=1, neg=0.
  - 5-5 -> sum=0, gray=0, carry=1, neg=0.
  - Results emerge in order, and the gap between acceptances is 2 cycles.
- Backpressure and full FIFO: hold out_ready=0 and issue 5 ops with FIFO_DEPTH=4. in_ready stays 0 after the 4th push and the 5th op is held. Assert out_ready for one cycle: one pop, then the 5th op is accepted. FIFO order is preserved; op 4 is 100+27 -> sum=127, gray=64, carry=0.
- Simultaneous push and pop: keep out_ready=1 continuously. Count stays at 0 or 1 and out_valid pulses once per result.
- Reset mid-operation: SETTLE=3, accept an op, then assert rst one cycle later. Outputs clear immediately (asynchronously), nothing is pushed, op_count=0, and in_ready=1 after rst deasserts.
